// File: rtl/nx_packer_pkg.sv
// Shared types and constants for the Nexus outbound stream packer.
// Pulled in with import nx_packer_pkg::*.
package nx_packer_pkg;

  localparam int         MSG_WIDTH = 32;
  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam logic [7:0] KEEP_HALF = 8'h0F;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    SEND  = 2'd2
  } state_e;

  // The first-received message always occupies the low slot of a beat.
  function automatic logic [2*MSG_WIDTH-1:0] pack_beat(
    input logic [MSG_WIDTH-1:0] hi,
    input logic [MSG_WIDTH-1:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/nx_stream_packer.sv
// Packs pairs of 32-bit messages into 64-bit AXI4-stream beats; lone messages go out as half beats.
// Define NX_PACKER_TIMEOUT_EN to add the FLUSH_CYCLES idle timeout on a held lone message.
module nx_stream_packer
  import nx_packer_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
  parameter int AXI4_ID_WIDTH   = 1,
  parameter int FLUSH_CYCLES    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [MSG_WIDTH-1:0]       msg_data_i,
  input  logic                       msg_valid_i,
  output logic                       msg_ready_o,
  input  logic                       flush_i,
  output logic [AXI4_DATA_WIDTH-1:0] outbound_tdata,
  output logic [AXI4_STRB_WIDTH-1:0] outbound_tkeep,
  output logic [AXI4_STRB_WIDTH-1:0] outbound_tstrb,
  output logic [AXI4_ID_WIDTH-1:0]   outbound_tid,
  output logic                       outbound_tlast,
  output logic                       outbound_tvalid,
  input  logic                       outbound_tready,
  output logic                       status_pending_o
);

  if (AXI4_DATA_WIDTH != 2 * MSG_WIDTH) begin : g_bad_width
    $error("nx_stream_packer: AXI4_DATA_WIDTH must be 64");
  end

`ifdef NX_PACKER_TIMEOUT_EN
  if (FLUSH_CYCLES < 1) begin : g_bad_flush
    $error("nx_stream_packer: FLUSH_CYCLES must be >= 1");
  end

  localparam int TIMER_W = $clog2(FLUSH_CYCLES + 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timeout;

  assign timeout = (timer_q == TIMER_W'(FLUSH_CYCLES - 1));
`endif

  state_e                     state_q, state_d;
  logic [MSG_WIDTH-1:0]       lo_q, lo_d;
  logic [AXI4_DATA_WIDTH-1:0] beat_q, beat_d;
  logic [AXI4_STRB_WIDTH-1:0] keep_q, keep_d;
  logic                       accept;
  logic                       half_exit;

  // Ready depends only on state and tready, never on msg_valid_i.
  assign msg_ready_o = (state_q != SEND) || outbound_tready;
  assign accept      = msg_valid_i && msg_ready_o;

`ifdef NX_PACKER_TIMEOUT_EN
  assign half_exit = flush_i || timeout;
`else
  assign half_exit = flush_i;
`endif

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    beat_d  = beat_q;
    keep_d  = keep_q;
`ifdef NX_PACKER_TIMEOUT_EN
    timer_d = timer_q;
`endif
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          lo_d    = msg_data_i;
          state_d = HALF;
`ifdef NX_PACKER_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      HALF: begin
        // A second message always beats a flush or timeout in the same cycle.
        if (accept) begin
          beat_d  = pack_beat(msg_data_i, lo_q);
          keep_d  = KEEP_FULL;
          state_d = SEND;
        end else if (half_exit) begin
          beat_d  = pack_beat('0, lo_q);
          keep_d  = KEEP_HALF;
          state_d = SEND;
        end
`ifdef NX_PACKER_TIMEOUT_EN
        else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      SEND: begin
        if (outbound_tready) begin
          if (accept) begin
            lo_d    = msg_data_i;
            state_d = HALF;
`ifdef NX_PACKER_TIMEOUT_EN
            timer_d = '0;
`endif
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      lo_q    <= '0;
      beat_q  <= '0;
      keep_q  <= '0;
`ifdef NX_PACKER_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      beat_q  <= beat_d;
      keep_q  <= keep_d;
`ifdef NX_PACKER_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  assign outbound_tvalid  = (state_q == SEND);
  assign outbound_tdata   = beat_q;
  assign outbound_tkeep   = outbound_tvalid ? keep_q : '0;
  assign outbound_tstrb   = outbound_tkeep;
  assign outbound_tid     = '0;
  assign outbound_tlast   = 1'b1;
  assign status_pending_o = (state_q == HALF);

endmodule

// File: tb/tb_nx_stream_packer.sv
// Directed plus randomized scoreboard bench for nx_stream_packer (FLUSH_CYCLES = 4).
// Timeout steps run only when NX_PACKER_TIMEOUT_EN is defined.
module tb_nx_stream_packer;

  logic        clk;
  logic        rst;
  logic [31:0] msgData;
  logic        msgValid;
  logic        msgReady;
  logic        flush;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [7:0]  tstrb;
  logic [0:0]  tid;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        pending;

  int vectors     = 0;
  int miscompares = 0;

  nx_stream_packer #(
    .AXI4_DATA_WIDTH(64),
    .AXI4_ID_WIDTH  (1),
    .FLUSH_CYCLES   (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .msg_data_i      (msgData),
    .msg_valid_i     (msgValid),
    .msg_ready_o     (msgReady),
    .flush_i         (flush),
    .outbound_tdata  (tdata),
    .outbound_tkeep  (tkeep),
    .outbound_tstrb  (tstrb),
    .outbound_tid    (tid),
    .outbound_tlast  (tlast),
    .outbound_tvalid (tvalid),
    .outbound_tready (tready),
    .status_pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic f, input logic r);
    msgValid = v;
    msgData  = d;
    flush    = f;
    tready   = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    logic [63:0] heldData;
    logic        prevStall;
    logic [63:0] prevData;
    logic [7:0]  prevKeep;
    int          accepted;
    int          cycles;

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_tvalid", tvalid, 0);
    checkOutput("rst_tdata", tdata, 0);
    checkOutput("rst_tkeep", tkeep, 0);
    checkOutput("rst_tstrb", tstrb, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_ready", msgReady, 1);
    checkOutput("tlast_const", tlast, 1);
    checkOutput("tid_const", tid, 0);

    applyStimulus(1'b1, 32'h0000_0001, 1'b0, 1'b1);
    tick();
    checkOutput("b2b_pending", pending, 1);
    checkOutput("b2b_notvalid", tvalid, 0);
    applyStimulus(1'b1, 32'h8000_0002, 1'b0, 1'b1);
    tick();
    checkOutput("b2b_tvalid", tvalid, 1);
    checkOutput("b2b_tdata", tdata, 64'h8000_0002_0000_0001);
    checkOutput("b2b_tkeep", tkeep, 8'hFF);
    checkOutput("b2b_tstrb", tstrb, 8'hFF);
    checkOutput("b2b_pending0", pending, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("b2b_drained", tvalid, 0);
    checkOutput("b2b_keep0", tkeep, 0);

    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("flush_tvalid", tvalid, 1);
    checkOutput("flush_tdata", tdata, 64'h0000_0000_1234_5678);
    checkOutput("flush_tkeep", tkeep, 8'h0F);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("flush_drained", tvalid, 0);

    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef NX_PACKER_TIMEOUT_EN
    tick();
    tick();
    tick();
    checkOutput("tmo_early", tvalid, 0);
    tick();
    checkOutput("tmo_tvalid", tvalid, 1);
    checkOutput("tmo_tdata", tdata, 64'h0000_0000_1234_5678);
    checkOutput("tmo_tkeep", tkeep, 8'h0F);
    tick();
    checkOutput("tmo_drained", tvalid, 0);

    applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 32'hBBBB_0002, 1'b0, 1'b1);
    tick();
    checkOutput("race_tdata", tdata, 64'hBBBB_0002_AAAA_0001);
    checkOutput("race_tkeep", tkeep, 8'hFF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
`else
    for (int i = 0; i < 6; i++) tick();
    checkOutput("notmo_pending", pending, 1);
    checkOutput("notmo_tvalid", tvalid, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("notmo_tdata", tdata, 64'h0000_0000_1234_5678);
    checkOutput("notmo_tkeep", tkeep, 8'h0F);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
`endif

    applyStimulus(1'b1, 32'hC000_000C, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_000D, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_000E, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #2;
      checkOutput("bp_ready", msgReady, 0);
      checkOutput("bp_tdata", tdata, 64'h0000_000D_C000_000C);
      checkOutput("bp_tkeep", tkeep, 8'hFF);
      tick();
    end
    applyStimulus(1'b1, 32'h0000_000E, 1'b0, 1'b1);
    #2;
    checkOutput("rel_ready", msgReady, 1);
    tick();
    checkOutput("rel_pending", pending, 1);
    checkOutput("rel_tvalid", tvalid, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("rel_tdata", tdata, 64'h0000_0000_0000_000E);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    applyStimulus(1'b1, 32'h0000_00F0, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    checkOutput("rsthalf_pending", pending, 0);
    checkOutput("rsthalf_tvalid", tvalid, 0);
    tick();
    checkOutput("rsthalf_nobeat", tvalid, 0);

    applyStimulus(1'b1, 32'h0000_0A01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_0A02, 1'b0, 1'b0);
    tick();
    checkOutput("rstsend_pre", tvalid, 1);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    checkOutput("rstsend_tvalid", tvalid, 0);
    checkOutput("rstsend_tdata", tdata, 0);
    checkOutput("rstsend_tkeep", tkeep, 0);
    checkOutput("rstsend_pending", pending, 0);

    accepted  = 0;
    cycles    = 0;
    prevStall = 1'b0;
    prevData  = '0;
    prevKeep  = '0;
    heldData  = 64'($urandom);
    while ((accepted < 1000 || q.size() != 0 || tvalid) && cycles < 20000) begin
      if (accepted < 1000)
        applyStimulus($urandom_range(0, 3) != 0, heldData[31:0],
                      $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      else
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      if (prevStall) begin
        checkOutput("rand_stable_data", tdata, prevData);
        checkOutput("rand_stable_keep", tkeep, prevKeep);
      end
      if (tvalid && tready) begin
        checkOutput("rand_keep_legal", (tkeep == 8'hFF) || (tkeep == 8'h0F), 1);
        if (q.size() == 0) checkOutput("rand_underflow", q.size(), 1);
        else checkOutput("rand_lo", tdata[31:0], q.pop_front());
        if (tkeep == 8'hFF) begin
          if (q.size() == 0) checkOutput("rand_underflow_hi", q.size(), 1);
          else checkOutput("rand_hi", tdata[63:32], q.pop_front());
        end else begin
          checkOutput("rand_hi_zero", tdata[63:32], 0);
        end
      end
      if (msgValid && msgReady) begin
        q.push_back(msgData);
        accepted++;
        heldData = 64'($urandom);
      end
      prevStall = tvalid && !tready;
      prevData  = tdata;
      prevKeep  = tkeep;
      tick();
      cycles++;
    end
    checkOutput("rand_all_delivered", q.size(), 0);
    checkOutput("rand_accepted", accepted, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
